// File: rtl/niosii_subsys_key_ctrl.sv
// Debounced key controller: per-key press/long/release FSMs feeding an event FIFO, Avalon-MM slave.
// Read data 1 cycle after strobe; no backpressure, events arriving at a full FIFO are dropped and flagged.
module niosii_subsys_key_ctrl #(
    parameter int NUM_KEYS       = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                read_n,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq,
    input  logic [NUM_KEYS-1:0] key_n
);

    localparam int TMAX = (LONG_TICKS > DEBOUNCE_TICKS) ? LONG_TICKS : DEBOUNCE_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(TICK_DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;

    localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_TICKS - 1);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(TICK_DIV - 1);

    localparam logic [1:0] EV_PRESS = 2'd0;
    localparam logic [1:0] EV_LONG  = 2'd1;
    localparam logic [1:0] EV_REL   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_LONG,
        S_REL_DB
    } key_state_t;

    logic [NUM_KEYS-1:0] sync1, sync2, pressed, db_state;
    logic [CW-1:0]       tick_cnt;
    logic                tick;

    key_state_t          state     [NUM_KEYS];
    logic [TW-1:0]       timer     [NUM_KEYS];
    logic [1:0]          pend_type [NUM_KEYS];
    logic [NUM_KEYS-1:0] from_long, pend_vld;

    logic                arb_vld;
    logic [3:0]          arb_key;
    logic [1:0]          arb_type;

    logic [5:0]          fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [NW-1:0]       count;
    logic [5:0]          head;
    logic                full, empty, pop, push_ok, ovf_evt;

    logic                irq_en, long_en, rel_en, overflow;
    logic                rd_en, wr_en, flush, ovf_clr;
    logic                unused_wdata;

    assign rd_en        = chipselect & ~read_n;
    assign wr_en        = chipselect & ~write_n;
    assign flush        = wr_en && (address == 2'd2) && writedata[8];
    assign ovf_clr      = wr_en && (address == 2'd3);
    assign unused_wdata = ^{writedata[31:9], writedata[7:3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_cnt == DIV_LAST);
            tick_cnt <= (tick_cnt == DIV_LAST) ? '0 : tick_cnt + CW'(1);
        end
    end

    // Event emission sets the pending slot after the arbiter clear, so a new event always survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i]     <= S_IDLE;
                timer[i]     <= '0;
                pend_type[i] <= '0;
            end
            from_long <= '0;
            pend_vld  <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (arb_vld && (arb_key == 4'(i)))
                    pend_vld[i] <= 1'b0;
                case (state[i])
                    S_IDLE: begin
                        if (pressed[i]) begin
                            state[i] <= S_PRESS_DB;
                            timer[i] <= '0;
                        end
                    end
                    S_PRESS_DB: begin
                        if (!pressed[i]) begin
                            state[i] <= S_IDLE;
                        end else if (tick) begin
                            if (timer[i] == DEB_LAST) begin
                                state[i]     <= S_HELD;
                                timer[i]     <= '0;
                                pend_vld[i]  <= 1'b1;
                                pend_type[i] <= EV_PRESS;
                            end else begin
                                timer[i] <= timer[i] + TW'(1);
                            end
                        end
                    end
                    S_HELD: begin
                        if (!pressed[i]) begin
                            state[i]     <= S_REL_DB;
                            timer[i]     <= '0;
                            from_long[i] <= 1'b0;
                        end else if (tick) begin
                            if (timer[i] == LONG_LAST) begin
                                state[i] <= S_LONG;
                                if (long_en) begin
                                    pend_vld[i]  <= 1'b1;
                                    pend_type[i] <= EV_LONG;
                                end
                            end else begin
                                timer[i] <= timer[i] + TW'(1);
                            end
                        end
                    end
                    S_LONG: begin
                        if (!pressed[i]) begin
                            state[i]     <= S_REL_DB;
                            timer[i]     <= '0;
                            from_long[i] <= 1'b1;
                        end
                    end
                    S_REL_DB: begin
                        if (pressed[i]) begin
                            state[i] <= from_long[i] ? S_LONG : S_HELD;
                        end else if (tick) begin
                            if (timer[i] == DEB_LAST) begin
                                state[i] <= S_IDLE;
                                if (rel_en) begin
                                    pend_vld[i]  <= 1'b1;
                                    pend_type[i] <= EV_REL;
                                end
                            end else begin
                                timer[i] <= timer[i] + TW'(1);
                            end
                        end
                    end
                    default: state[i] <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        db_state = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            db_state[i] = (state[i] == S_HELD) || (state[i] == S_LONG) || (state[i] == S_REL_DB);
    end

    // Lowest-index pending key wins.
    always_comb begin
        arb_vld  = 1'b0;
        arb_key  = '0;
        arb_type = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend_vld[i]) begin
                arb_vld  = 1'b1;
                arb_key  = 4'(i);
                arb_type = pend_type[i];
            end
        end
    end

    assign full    = (count == NW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = rd_en && (address == 2'd1) && !empty;
    assign push_ok = arb_vld && (!full || pop);
    assign ovf_evt = arb_vld && full && !pop && !flush;
    assign head    = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            fifo_mem[wr_ptr] <= {arb_type, arb_key};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en   <= 1'b0;
            long_en  <= 1'b0;
            rel_en   <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && (address == 2'd2))
                {rel_en, long_en, irq_en} <= writedata[2:0];
            if (ovf_evt)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            irq <= irq_en && !empty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            case (address)
                2'd0:    readdata <= 32'(db_state);
                2'd1:    readdata <= empty ? 32'd0 : {1'b1, 13'd0, head[5:4], 12'd0, head[3:0]};
                2'd2:    readdata <= {29'd0, rel_en, long_en, irq_en};
                default: readdata <= {23'd0, overflow, 1'b0, 7'(count)};
            endcase
        end else begin
            readdata <= '0;
        end
    end

endmodule
